// File: rtl/reduce_pkg.sv
// Shared types and constants for the reduce_stream block.
//   state_t       - controller state encoding (IDLE, ACCUM, HOLD)
//   RES_*         - bit positions inside the six-bit result record
//   pack_res()    - builds the result record from the three packet reductions
package reduce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int RES_W    = 6;
    localparam int RES_AND  = 0;
    localparam int RES_NAND = 1;
    localparam int RES_OR   = 2;
    localparam int RES_NOR  = 3;
    localparam int RES_XOR  = 4;
    localparam int RES_XNOR = 5;

    function automatic logic [RES_W-1:0] pack_res(input logic a, input logic o, input logic x);
        logic [RES_W-1:0] r;
        r           = '0;
        r[RES_AND]  = a;
        r[RES_NAND] = ~a;
        r[RES_OR]   = o;
        r[RES_NOR]  = ~o;
        r[RES_XOR]  = x;
        r[RES_XNOR] = ~x;
        return r;
    endfunction

endpackage

// File: rtl/reduce_beat.sv
// Combinational reducer for a single W-bit beat.
// Optional build macro: REDUCE_POPCOUNT_EN (adds the popcnt output).
//   data     in  W      beat data
//   red_and  out 1      AND of all bits
//   red_or   out 1      OR of all bits
//   red_xor  out 1      XOR of all bits
//   popcnt   out PCB_W  number of ones in the beat (REDUCE_POPCOUNT_EN only)
module reduce_beat #(
    parameter int W     = 4,
    parameter int PCB_W = $clog2(W + 1)
) (
    input  logic [W-1:0] data,
    output logic         red_and,
    output logic         red_or,
    output logic         red_xor
`ifdef REDUCE_POPCOUNT_EN
    ,
    output logic [PCB_W-1:0] popcnt
`endif
);

    assign red_and = &data;
    assign red_or  = |data;
    assign red_xor = ^data;

`ifdef REDUCE_POPCOUNT_EN
    assign popcnt = PCB_W'($countones(data));
`endif

endmodule

// File: rtl/reduce_stream.sv
// Streaming packet reducer: accumulates AND/OR/XOR over every bit of every
// accepted beat and presents a registered result record once per packet.
// Optional build macro: REDUCE_POPCOUNT_EN (adds the packet popcount).
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input beat handshake; in_data, in_last beat payload
//   out_valid/out_ready  result handshake
//   out_res              {xnor, xor, nor, or, nand, and} over the whole packet
//   out_beats, out_ovf   saturating beat count and saturation flag
//   out_popcnt           total ones in packet (REDUCE_POPCOUNT_EN only)
//
// state | meaning
// IDLE  | no beat of the current packet seen yet
// ACCUM | mid-packet, accumulating
// HOLD  | result record valid, waiting for out_ready; input blocked
module reduce_stream
    import reduce_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8,
    parameter int PC_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
`ifdef REDUCE_POPCOUNT_EN
    ,
    output logic [PC_W-1:0]  out_popcnt
`endif
);

    localparam int PCB_W = $clog2(W + 1);

    if (W < 1) begin : g_bad_w
        $error("reduce_stream: W must be at least 1");
    end
    if (PC_W < PCB_W) begin : g_bad_pc_w
        $error("reduce_stream: PC_W too narrow for one beat");
    end

    state_t state, state_nxt;

    logic             acc_and, acc_or, acc_xor, acc_ovf;
    logic [CNT_W-1:0] cnt;
    logic             red_and, red_or, red_xor;
    logic             beat_acc;
    logic             and_nxt, or_nxt, xor_nxt, ovf_nxt;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef REDUCE_POPCOUNT_EN
    logic [PCB_W-1:0] beat_pc;
    logic [PC_W-1:0]  acc_pc;
    logic [PC_W:0]    pc_sum;
    logic [PC_W-1:0]  pc_nxt;
`endif

    reduce_beat #(
        .W     (W),
        .PCB_W (PCB_W)
    ) u_beat (
        .data    (in_data),
        .red_and (red_and),
        .red_or  (red_or),
        .red_xor (red_xor)
`ifdef REDUCE_POPCOUNT_EN
        ,
        .popcnt  (beat_pc)
`endif
    );

    assign beat_acc = in_valid & in_ready;

    // Packet values including the current beat; these feed both the
    // accumulators and, on the last beat, the result registers.
    assign and_nxt = acc_and & red_and;
    assign or_nxt  = acc_or | red_or;
    assign xor_nxt = acc_xor ^ red_xor;
    assign cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign ovf_nxt = acc_ovf | (&cnt);

`ifdef REDUCE_POPCOUNT_EN
    assign pc_sum = {1'b0, acc_pc} + (PC_W + 1)'(beat_pc);
    assign pc_nxt = pc_sum[PC_W] ? '1 : pc_sum[PC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (beat_acc) begin
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: in_ready  = 1'b1;
            HOLD:        out_valid = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_and   <= 1'b1;
            acc_or    <= 1'b0;
            acc_xor   <= 1'b0;
            acc_ovf   <= 1'b0;
            cnt       <= '0;
            out_res   <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
`ifdef REDUCE_POPCOUNT_EN
            acc_pc     <= '0;
            out_popcnt <= '0;
`endif
        end else if (state == HOLD) begin
            // Result registers keep their values after release; only the
            // accumulators are cleared for the next packet.
            if (out_ready) begin
                acc_and <= 1'b1;
                acc_or  <= 1'b0;
                acc_xor <= 1'b0;
                acc_ovf <= 1'b0;
                cnt     <= '0;
`ifdef REDUCE_POPCOUNT_EN
                acc_pc  <= '0;
`endif
            end
        end else if (beat_acc) begin
            acc_and <= and_nxt;
            acc_or  <= or_nxt;
            acc_xor <= xor_nxt;
            acc_ovf <= ovf_nxt;
            cnt     <= cnt_nxt;
`ifdef REDUCE_POPCOUNT_EN
            acc_pc  <= pc_nxt;
`endif
            if (in_last) begin
                out_res   <= pack_res(and_nxt, or_nxt, xor_nxt);
                out_beats <= cnt_nxt;
                out_ovf   <= ovf_nxt;
`ifdef REDUCE_POPCOUNT_EN
                out_popcnt <= pc_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_reduce_stream.sv
module tb_reduce_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid, out_ovf;
    logic [5:0] out_res;
    logic [7:0] out_beats;

    logic       v2, l2, ordy2;
    logic [3:0] d2;
    logic       rdy2, ov2, ovf2;
    logic [5:0] res2;
    logic [1:0] beats2;

`ifdef REDUCE_POPCOUNT_EN
    logic [15:0] out_popcnt;
    logic [15:0] pc2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reduce_stream #(.W(4), .CNT_W(8), .PC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_beats (out_beats),
        .out_ovf   (out_ovf)
`ifdef REDUCE_POPCOUNT_EN
        ,
        .out_popcnt(out_popcnt)
`endif
    );

    reduce_stream #(.W(4), .CNT_W(2), .PC_W(16)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2),
        .in_ready  (rdy2),
        .in_data   (d2),
        .in_last   (l2),
        .out_valid (ov2),
        .out_ready (ordy2),
        .out_res   (res2),
        .out_beats (beats2),
        .out_ovf   (ovf2)
`ifdef REDUCE_POPCOUNT_EN
        ,
        .out_popcnt(pc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_data  = 4'bxxxx;
        in_last  = 1'bx;
    endtask

    task automatic release_res(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        v2 = 1'b0; d2 = '0; l2 = 1'b0; ordy2 = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);
        chk("rst_out_beats", 32'(out_beats), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`ifdef REDUCE_POPCOUNT_EN
        chk("rst_out_popcnt", 32'(out_popcnt), 32'd0);
`endif

        // single beat 0110
        beat(4'b0110, 1'b1);
        chk("b0110_valid", 32'(out_valid), 32'd1);
        chk("b0110_res", 32'(out_res), 32'b100110);
        chk("b0110_beats", 32'(out_beats), 32'd1);
        chk("b0110_ovf", 32'(out_ovf), 32'd0);
        chk("b0110_in_ready", 32'(in_ready), 32'd0);
        release_res("b0110");
        chk("b0110_res_kept", 32'(out_res), 32'b100110);

        beat(4'b1000, 1'b1);
        chk("b1000_res", 32'(out_res), 32'b010110);
        chk("b1000_beats", 32'(out_beats), 32'd1);
        release_res("b1000");

        beat(4'b0000, 1'b1);
        chk("b0000_res", 32'(out_res), 32'b101010);
        release_res("b0000");

        // two-beat all-ones packet, then backpressure
        beat(4'b1111, 1'b0);
        chk("p11_mid_valid", 32'(out_valid), 32'd0);
        beat(4'b1111, 1'b1);
        chk("p11_res", 32'(out_res), 32'b100101);
        chk("p11_beats", 32'(out_beats), 32'd2);
`ifdef REDUCE_POPCOUNT_EN
        chk("p11_popcnt", 32'(out_popcnt), 32'd8);
`endif
        // source presents a beat during HOLD; it must be ignored
        in_valid = 1'b1; in_data = 4'b0000; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_res", 32'(out_res), 32'b100101);
            chk("bp_beats", 32'(out_beats), 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_res("bp");

        // and-accumulation across beats: 0111 then 1111
        beat(4'b0111, 1'b0);
        beat(4'b1111, 1'b1);
        chk("p71_res", 32'(out_res), 32'b010110);
        chk("p71_beats", 32'(out_beats), 32'd2);
`ifdef REDUCE_POPCOUNT_EN
        chk("p71_popcnt", 32'(out_popcnt), 32'd7);
`endif
        release_res("p71");

        // saturating counter on the CNT_W=2 instance
        chk("sat_rst_ready", 32'(rdy2), 32'd1);
        for (int i = 0; i < 5; i++) begin
            v2 = 1'b1; d2 = 4'b1111; l2 = (i == 4);
            tick();
        end
        v2 = 1'b0;
        chk("sat_valid", 32'(ov2), 32'd1);
        chk("sat_beats", 32'(beats2), 32'd3);
        chk("sat_ovf", 32'(ovf2), 32'd1);
        chk("sat_res", 32'(res2), 32'b100101);
`ifdef REDUCE_POPCOUNT_EN
        chk("sat_popcnt", 32'(pc2), 32'd20);
`endif
        ordy2 = 1'b1;
        tick();
        ordy2 = 1'b0;
        chk("sat_rel_valid", 32'(ov2), 32'd0);

        // reset mid-packet
        beat(4'b1111, 1'b0);
        beat(4'b1111, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_res", 32'(out_res), 32'd0);
        chk("mrst_out_beats", 32'(out_beats), 32'd0);
        chk("mrst_out_ovf", 32'(out_ovf), 32'd0);
        beat(4'b0110, 1'b1);
        chk("mrst_after_res", 32'(out_res), 32'b100110);
        chk("mrst_after_beats", 32'(out_beats), 32'd1);
`ifdef REDUCE_POPCOUNT_EN
        chk("mrst_after_popcnt", 32'(out_popcnt), 32'd2);
`endif
        release_res("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
